// File: rtl/digit_serial_adder.sv
// Digit-serial adder: sums two WIDTH-bit operands two bits per clock through a
// single 2-bit full adder, trading WIDTH/2 cycles of latency for a short carry chain.

module full_adder_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};
endmodule

module digit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p_next;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [1:0]       digit_s;
    logic             digit_c;

    full_adder_2bit u_fa (
        .a    (a_sh[1:0]),
        .b    (b_sh[1:0]),
        .cin  (carry_q),
        .s    (digit_s),
        .cout (digit_c)
    );

    // The newest digit enters at the top so that after N shifts digit 0 sits in bits [1:0].
    if (WIDTH == 2) begin : g_p_single
        assign p_next = digit_s;
    end else begin : g_p_shift
        assign p_next = {digit_s, p[WIDTH-1:2]};
    end

    // NOTE: every register here is a flop updated with <=, so all reads in this block
    // see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            p       <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        p       <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    p       <= p_next;
                    a_sh    <= a_sh >> 2;
                    b_sh    <= b_sh >> 2;
                    carry_q <= digit_c;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        // Result registers load only here, so they never expose a partial sum.
                        sum   <= p_next;
                        cout  <= digit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder at WIDTH=2, 8 and 16 against an
// arithmetic reference model of the operation timing and result.

module tb_digit_serial_adder;
    localparam int LANES = 3;

    function automatic int lane_w(input int l);
        return (l == 0) ? 2 : (l == 1) ? 8 : 16;
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st [LANES];
    logic [15:0] av [LANES];
    logic [15:0] bv [LANES];
    logic        ci [LANES];
    logic        busy_o [LANES];
    logic        done_o [LANES];
    logic [16:0] res_o [LANES];

    logic [1:0]  s2;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic        c2, c8, c16, bz2, bz8, bz16, dn2, dn8, dn16;

    digit_serial_adder #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][1:0]), .b(bv[0][1:0]),
        .cin(ci[0]), .busy(bz2), .done(dn2), .sum(s2), .cout(c2));
    digit_serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
        .cin(ci[1]), .busy(bz8), .done(dn8), .sum(s8), .cout(c8));
    digit_serial_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]),
        .cin(ci[2]), .busy(bz16), .done(dn16), .sum(s16), .cout(c16));

    assign busy_o[0] = bz2;
    assign busy_o[1] = bz8;
    assign busy_o[2] = bz16;
    assign done_o[0] = dn2;
    assign done_o[1] = dn8;
    assign done_o[2] = dn16;
    assign res_o[0]  = {14'd0, c2, s2};
    assign res_o[1]  = {8'd0, c8, s8};
    assign res_o[2]  = {c16, s16};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase counts cycles since accept; 1..N busy, N+1 done.
    int          phase [LANES];
    logic [16:0] pend [LANES];
    logic [16:0] exp_res [LANES];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                phase[l]   <= 0;
                pend[l]    <= '0;
                exp_res[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                logic [15:0] m;
                m = 16'((17'h1 << lane_w(l)) - 17'h1);
                if (phase[l] == 0) begin
                    if (st[l]) begin
                        phase[l] <= 1;
                        pend[l]  <= 17'(av[l] & m) + 17'(bv[l] & m) + 17'(ci[l]);
                    end
                end else if (phase[l] == lane_w(l) / 2) begin
                    phase[l]   <= phase[l] + 1;
                    exp_res[l] <= pend[l];
                end else if (phase[l] == lane_w(l) / 2 + 1) begin
                    phase[l] <= 0;
                end else begin
                    phase[l] <= phase[l] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            int n;
            n = lane_w(l) / 2;
            check($sformatf("busy_w%0d", lane_w(l)), 32'(busy_o[l]),
                  32'(phase[l] >= 1 && phase[l] <= n));
            check($sformatf("done_w%0d", lane_w(l)), 32'(done_o[l]), 32'(phase[l] == n + 1));
            check($sformatf("result_w%0d", lane_w(l)), 32'(res_o[l]), 32'(exp_res[l]));
        end
    end

    // Directed operation on the WIDTH=8 instance with latency, busy-length and result checks.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                          input logic [8:0] expv, input string tag);
        int edges;
        int nb;
        bit found;
        @(posedge clk);
        #2;
        st[1] = 1'b1; av[1] = {8'd0, x}; bv[1] = {8'd0, y}; ci[1] = c;
        @(posedge clk);
        #1;
        nb = int'(busy_o[1]);
        #1;
        st[1] = 1'b0;
        edges = 0;
        found = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (done_o[1]) begin
                found = 1;
                edges = k;
            end else begin
                nb += int'(busy_o[1]);
            end
        end
        check({tag, "_latency"}, 32'(edges), 32'd4);
        check({tag, "_busy_cycles"}, 32'(nb), 32'd4);
        check({tag, "_result"}, 32'(res_o[1]), 32'(expv));
        check({tag, "_model_pin"}, 32'(exp_res[1]), 32'(expv));
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            cnt += int'(done_o[1]);
        end
    endtask

    initial begin
        int nd;
        int found;
        int times [$];
        int cyc;

        for (int l = 0; l < LANES; l++) begin
            st[l] = 1'b0; av[l] = '0; bv[l] = '0; ci[l] = 1'b0;
        end
        #12;
        check("reset_busy", 32'(busy_o[1]), 32'd0);
        check("reset_done", 32'(done_o[1]), 32'd0);
        check("reset_result", 32'(res_o[1]), 32'd0);
        #2;
        rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 9'h096, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
        run_op(8'hFF, 8'h00, 1'b1, 9'h100, "add_ff_00_c");
        run_op(8'h00, 8'h00, 1'b1, 9'h001, "add_00_00_c");

        // start re-asserted during RUN, operands changed mid-operation
        @(posedge clk);
        #2;
        st[1] = 1'b1; av[1] = 16'h5A; bv[1] = 16'h3C; ci[1] = 1'b0;
        @(posedge clk);
        #2;
        av[1] = 16'h11; bv[1] = 16'h11;
        @(posedge clk);
        #2;
        av[1] = 16'($urandom_range(0, 255)); bv[1] = 16'($urandom_range(0, 255));
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(posedge clk);
            #1;
            if (done_o[1]) found = 1;
        end
        #1;
        st[1] = 1'b0;
        check("busy_start_done_seen", 32'(found), 32'd1);
        check("busy_start_result", 32'(res_o[1]), 32'h096);
        count_done(10, nd);
        check("busy_start_no_second_done", 32'(nd), 32'd0);

        // asynchronous reset during the third RUN cycle
        @(posedge clk);
        #2;
        st[1] = 1'b1; av[1] = 16'h77; bv[1] = 16'h11; ci[1] = 1'b1;
        @(posedge clk);
        #2;
        st[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy_o[1]), 32'd0);
        check("midreset_done", 32'(done_o[1]), 32'd0);
        check("midreset_result", 32'(res_o[1]), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        count_done(8, nd);
        check("midreset_no_done", 32'(nd), 32'd0);
        run_op(8'h01, 8'h02, 1'b0, 9'h003, "after_reset");

        // start held high: accepts must be N+2 cycles apart
        @(posedge clk);
        #2;
        st[1] = 1'b1;
        cyc = 0;
        repeat (40) begin
            av[1] = 16'($urandom_range(0, 255));
            bv[1] = 16'($urandom_range(0, 255));
            ci[1] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
            if (done_o[1]) times.push_back(cyc);
            #1;
        end
        st[1] = 1'b0;
        check("b2b_done_count", 32'(times.size() >= 5), 32'd1);
        for (int i = 1; i < times.size(); i++)
            check($sformatf("b2b_spacing_%0d", i), 32'(times[i] - times[i-1]), 32'd6);
        repeat (8) @(posedge clk);

        // randomized regression on all three widths concurrently
        repeat (20000) begin
            @(posedge clk);
            #2;
            for (int l = 0; l < LANES; l++) begin
                logic [15:0] m;
                m = 16'((17'h1 << lane_w(l)) - 17'h1);
                st[l] = ($urandom_range(0, 3) != 0);
                av[l] = 16'($urandom) & m;
                bv[l] = 16'($urandom) & m;
                ci[l] = 1'($urandom_range(0, 1));
            end
        end
        for (int l = 0; l < LANES; l++) st[l] = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
